// File: rtl/glitc_trigger_pkg.sv
// rtl/glitc_trigger_pkg.sv - shared constants and types for the GLITC trigger holdoff block
package glitc_trigger_pkg;

    localparam logic [1:0] ADDR_CFG    = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_VETO0  = 2'd2;
    localparam logic [1:0] ADDR_VETO1  = 2'd3;

    localparam int CFG_WIDTH_LSB   = 0;
    localparam int CFG_HOLDOFF_LSB = 8;
    localparam int CFG_MASK_LSB    = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } chan_state_t;

endpackage

// File: rtl/glitc_trigger_holdoff_chan.sv
// rtl/glitc_trigger_holdoff_chan.sv - one trigger channel: edge detect, pulse/holdoff FSM, veto counter
import glitc_trigger_pkg::*;

module glitc_trigger_holdoff_chan #(
    parameter int WIDTH_BITS   = 4,
    parameter int HOLDOFF_BITS = 8,
    parameter int VETO_BITS    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    trig,
    input  logic                    mask,
    input  logic [WIDTH_BITS-1:0]   width,
    input  logic [HOLDOFF_BITS-1:0] holdoff,
    input  logic                    veto_clr,
    output logic                    pulse,
    output logic                    busy,
    output logic [VETO_BITS-1:0]    veto_cnt
);

    chan_state_t             state;
    logic                    trig_q;
    logic                    trig_edge;
    logic                    veto_hit;
    logic [WIDTH_BITS-1:0]   pcnt;
    logic [HOLDOFF_BITS-1:0] hcnt;
    logic [HOLDOFF_BITS-1:0] hcnt_load;

    assign trig_edge = trig & ~trig_q;
    assign veto_hit  = trig_edge & ~mask & (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig;
        end
    end

    // pulse/busy are registered alongside the state so they track it exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pcnt      <= '0;
            hcnt      <= '0;
            hcnt_load <= '0;
            pulse     <= 1'b0;
            busy      <= 1'b0;
        end else if (mask) begin
            state <= IDLE;
            pulse <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig_edge) begin
                        state     <= PULSE;
                        pcnt      <= (width == '0) ? WIDTH_BITS'(1) : width;
                        hcnt_load <= holdoff;
                        pulse     <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                PULSE: begin
                    if (pcnt == WIDTH_BITS'(1)) begin
                        pulse <= 1'b0;
                        if (hcnt_load != '0) begin
                            state <= HOLDOFF;
                            hcnt  <= hcnt_load;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        pcnt <= pcnt - WIDTH_BITS'(1);
                    end
                end
                HOLDOFF: begin
                    if (hcnt == HOLDOFF_BITS'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hcnt <= hcnt - HOLDOFF_BITS'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    pulse <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // a clear in the same cycle as a veto wins; the counter sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            veto_cnt <= '0;
        end else if (veto_clr) begin
            veto_cnt <= '0;
        end else if (veto_hit && (veto_cnt != '1)) begin
            veto_cnt <= veto_cnt + VETO_BITS'(1);
        end
    end

endmodule

// File: rtl/glitc_trigger_holdoff.sv
// rtl/glitc_trigger_holdoff.sv - two-channel trigger stretcher with holdoff and veto counters
import glitc_trigger_pkg::*;

module glitc_trigger_holdoff #(
    parameter int WIDTH_BITS   = 4,
    parameter int HOLDOFF_BITS = 8,
    parameter int VETO_BITS    = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [1:0]  trig_i,
    output logic [1:0]  trig_o,
    output logic [1:0]  busy_o,
    input  logic        reg_wr_i,
    input  logic [1:0]  reg_addr_i,
    input  logic [31:0] reg_dat_i,
    output logic [31:0] reg_dat_o
);

    logic [WIDTH_BITS-1:0]   cfg_width;
    logic [HOLDOFF_BITS-1:0] cfg_holdoff;
    logic [1:0]              cfg_mask;
    logic [1:0]              veto_clr;
    logic [VETO_BITS-1:0]    veto0;
    logic [VETO_BITS-1:0]    veto1;
    logic                    unused_dat;

    assign unused_dat = ^reg_dat_i;
    assign veto_clr[0] = reg_wr_i && (reg_addr_i == ADDR_VETO0);
    assign veto_clr[1] = reg_wr_i && (reg_addr_i == ADDR_VETO1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cfg_width   <= WIDTH_BITS'(1);
            cfg_holdoff <= HOLDOFF_BITS'(16);
            cfg_mask    <= 2'b11;
        end else if (reg_wr_i && (reg_addr_i == ADDR_CFG)) begin
            cfg_width   <= reg_dat_i[CFG_WIDTH_LSB +: WIDTH_BITS];
            cfg_holdoff <= reg_dat_i[CFG_HOLDOFF_LSB +: HOLDOFF_BITS];
            cfg_mask    <= reg_dat_i[CFG_MASK_LSB +: 2];
        end
    end

    always_comb begin
        reg_dat_o = '0;
        case (reg_addr_i)
            ADDR_CFG: begin
                reg_dat_o[CFG_WIDTH_LSB +: WIDTH_BITS]     = cfg_width;
                reg_dat_o[CFG_HOLDOFF_LSB +: HOLDOFF_BITS] = cfg_holdoff;
                reg_dat_o[CFG_MASK_LSB +: 2]               = cfg_mask;
            end
            ADDR_STATUS: reg_dat_o[1:0]           = busy_o;
            ADDR_VETO0:  reg_dat_o[VETO_BITS-1:0] = veto0;
            default:     reg_dat_o[VETO_BITS-1:0] = veto1;
        endcase
    end

    glitc_trigger_holdoff_chan #(
        .WIDTH_BITS  (WIDTH_BITS),
        .HOLDOFF_BITS(HOLDOFF_BITS),
        .VETO_BITS   (VETO_BITS)
    ) u_chan0 (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .trig    (trig_i[0]),
        .mask    (cfg_mask[0]),
        .width   (cfg_width),
        .holdoff (cfg_holdoff),
        .veto_clr(veto_clr[0]),
        .pulse   (trig_o[0]),
        .busy    (busy_o[0]),
        .veto_cnt(veto0)
    );

    glitc_trigger_holdoff_chan #(
        .WIDTH_BITS  (WIDTH_BITS),
        .HOLDOFF_BITS(HOLDOFF_BITS),
        .VETO_BITS   (VETO_BITS)
    ) u_chan1 (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .trig    (trig_i[1]),
        .mask    (cfg_mask[1]),
        .width   (cfg_width),
        .holdoff (cfg_holdoff),
        .veto_clr(veto_clr[1]),
        .pulse   (trig_o[1]),
        .busy    (busy_o[1]),
        .veto_cnt(veto1)
    );

endmodule

// File: tb/tb_glitc_trigger_holdoff.sv
// tb/tb_glitc_trigger_holdoff.sv - directed self-checking bench for glitc_trigger_holdoff
module tb_glitc_trigger_holdoff;

    logic        clk;
    logic        rst_n;
    logic [1:0]  trig_i;
    logic [1:0]  trig_o;
    logic [1:0]  busy_o;
    logic        reg_wr;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdat;
    logic [31:0] reg_rdat;

    int total = 0;
    int bad   = 0;

    glitc_trigger_holdoff u_dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .trig_i    (trig_i),
        .trig_o    (trig_o),
        .busy_o    (busy_o),
        .reg_wr_i  (reg_wr),
        .reg_addr_i(reg_addr),
        .reg_dat_i (reg_wdat),
        .reg_dat_o (reg_rdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        reg_wr   = 1'b1;
        reg_addr = a;
        reg_wdat = d;
        @(negedge clk);
        reg_wr   = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        reg_addr = a;
        #1;
        d = reg_rdat;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        int hi;
        rst_n = 1'b0; trig_i = 2'b00; reg_wr = 1'b0; reg_addr = 2'd0; reg_wdat = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        reg_read(2'd0, d);
        total++; if (d !== 32'h0003_1001) begin bad++; $display("FAIL reset_cfg got=%h exp=%h", d, 32'h0003_1001); end
        reg_read(2'd1, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", d); end
        hi = 0;
        for (int k = 0; k < 8; k++) begin
            trig_i = (k % 2 == 0) ? 2'b11 : 2'b00;
            @(negedge clk);
            if (trig_o !== 2'b00) hi++;
        end
        trig_i = 2'b00;
        total++; if (hi !== 0) begin bad++; $display("FAIL masked_trig got=%0d exp=0 high cycles", hi); end
        reg_read(2'd2, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL masked_veto0 got=%h exp=0", d); end
        reg_read(2'd3, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL masked_veto1 got=%h exp=0", d); end
    endtask

    task automatic test_no_holdoff;
        logic [31:0] d;
        reg_write(2'd0, 32'h0000_0003);
        trig_i = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            trig_i = 2'b00;
            total++; if (trig_o !== 2'b01) begin bad++; $display("FAIL nohold_pulse k=%0d got=%b exp=01", k, trig_o); end
        end
        @(negedge clk);
        total++; if (busy_o !== 2'b00) begin bad++; $display("FAIL nohold_idle got=%b exp=00", busy_o); end
        trig_i = 2'b01;
        @(negedge clk);
        trig_i = 2'b00;
        total++; if (trig_o !== 2'b01) begin bad++; $display("FAIL nohold_reaccept got=%b exp=01", trig_o); end
        repeat (4) @(negedge clk);
        reg_read(2'd2, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL nohold_veto got=%h exp=0", d); end
    endtask

    task automatic test_veto;
        logic [31:0] d;
        logic exp_p, exp_b;
        reg_write(2'd0, 32'h0000_0502);
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            exp_p = (k >= 1 && k <= 2);
            exp_b = (k >= 1 && k <= 7);
            total++; if (trig_o[0] !== exp_p || busy_o[0] !== exp_b) begin bad++;
                $display("FAIL veto_seq k=%0d got=%b/%b exp=%b/%b", k, trig_o[0], busy_o[0], exp_p, exp_b); end
            trig_i = {1'b0, (k == 0 || k == 7)};
        end
        reg_read(2'd2, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL veto_count got=%h exp=1", d); end
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(negedge clk);
            exp_p = (k >= 1 && k <= 2) || (k >= 9 && k <= 10);
            exp_b = (k >= 1 && k <= 7) || (k >= 9 && k <= 15);
            total++; if (trig_o[0] !== exp_p || busy_o[0] !== exp_b) begin bad++;
                $display("FAIL reaccept_seq k=%0d got=%b/%b exp=%b/%b", k, trig_o[0], busy_o[0], exp_p, exp_b); end
            trig_i = {1'b0, (k == 0 || k == 8)};
        end
        reg_read(2'd2, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL reaccept_veto got=%h exp=1", d); end
    endtask

    task automatic test_both;
        logic [1:0] exp_p, exp_b;
        reg_write(2'd0, 32'h0000_0101);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) @(negedge clk);
            exp_p = (k == 1) ? 2'b11 : 2'b00;
            exp_b = (k == 1 || k == 2) ? 2'b11 : 2'b00;
            total++; if (trig_o !== exp_p || busy_o !== exp_b) begin bad++;
                $display("FAIL both_seq k=%0d got=%b/%b exp=%b/%b", k, trig_o, busy_o, exp_p, exp_b); end
            trig_i = (k == 0) ? 2'b11 : 2'b00;
        end
    endtask

    task automatic test_level_hold;
        logic [31:0] d;
        int hi1, hi0;
        reg_write(2'd0, 32'h0000_0502);
        hi1 = 0; hi0 = 0;
        trig_i = 2'b10;
        for (int k = 0; k < 110; k++) begin
            @(negedge clk);
            if (k == 99) trig_i = 2'b00;
            if (trig_o[1]) hi1++;
            if (trig_o[0]) hi0++;
        end
        total++; if (hi1 !== 2 || hi0 !== 0) begin bad++; $display("FAIL level_hold got=%0d/%0d exp=2/0 high cycles", hi1, hi0); end
        reg_read(2'd3, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL level_veto1 got=%h exp=0", d); end
    endtask

    task automatic test_saturate;
        logic [31:0] d;
        force u_dut.u_chan0.veto_cnt = 16'hFFFF;
        @(negedge clk);
        release u_dut.u_chan0.veto_cnt;
        @(negedge clk);
        reg_read(2'd2, d);
        total++; if (d !== 32'h0000_FFFF) begin bad++; $display("FAIL preload got=%h exp=0000ffff", d); end
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) @(negedge clk);
            trig_i = {1'b0, (k == 0 || k == 4)};
        end
        reg_read(2'd2, d);
        total++; if (d !== 32'h0000_FFFF) begin bad++; $display("FAIL saturate got=%h exp=0000ffff", d); end
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) @(negedge clk);
            trig_i = {1'b0, (k == 0 || k == 4)};
            reg_addr = 2'd2;
            reg_wr   = (k == 4);
        end
        reg_read(2'd2, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL clear_wins got=%h exp=0", d); end
    endtask

    task automatic test_width_zero;
        logic [31:0] d;
        logic exp_p, exp_b;
        int hi;
        reg_write(2'd0, 32'h0000_0800);
        for (int k = 0; k <= 11; k++) begin
            if (k > 0) @(negedge clk);
            exp_p = (k == 1);
            exp_b = (k >= 1 && k <= 9);
            total++; if (trig_o[0] !== exp_p || busy_o[0] !== exp_b) begin bad++;
                $display("FAIL w0_seq k=%0d got=%b/%b exp=%b/%b", k, trig_o[0], busy_o[0], exp_p, exp_b); end
            trig_i = {1'b0, (k == 0)};
        end
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) @(negedge clk);
            exp_b = (k >= 1 && k <= 3);
            total++; if (busy_o[0] !== exp_b) begin bad++;
                $display("FAIL mask_drop k=%0d got=%b exp=%b", k, busy_o[0], exp_b); end
            trig_i   = {1'b0, (k == 0)};
            reg_wr   = (k == 2);
            reg_addr = 2'd0;
            reg_wdat = 32'h0001_0800;
        end
        hi = 0;
        trig_i = 2'b01;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            trig_i = 2'b00;
            if (trig_o[0] || busy_o[0]) hi++;
        end
        total++; if (hi !== 0) begin bad++; $display("FAIL masked_idle got=%0d exp=0 busy cycles", hi); end
        reg_read(2'd2, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL masked_noveto got=%h exp=0", d); end
    endtask

    task automatic test_reset_mid_pulse;
        logic [31:0] d;
        reg_write(2'd0, 32'h0000_0205);
        trig_i = 2'b01;
        @(negedge clk);
        trig_i = 2'b00;
        @(negedge clk);
        total++; if (trig_o !== 2'b01) begin bad++; $display("FAIL pre_reset got=%b exp=01", trig_o); end
        rst_n = 1'b0;
        #1;
        total++; if (trig_o !== 2'b00 || busy_o !== 2'b00) begin bad++;
            $display("FAIL async_reset got=%b/%b exp=00/00", trig_o, busy_o); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        reg_read(2'd0, d);
        total++; if (d !== 32'h0003_1001) begin bad++; $display("FAIL post_reset_cfg got=%h exp=%h", d, 32'h0003_1001); end
    endtask

    initial begin
        test_reset();
        test_no_holdoff();
        test_veto();
        test_both();
        test_level_hold();
        test_saturate();
        test_width_zero();
        test_reset_mid_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
